// File: rtl/dealer_pkg.sv
// Shared types and constants for the poker-hand dealer sequencer.
// Contents: FSM state enum, deal-phase enum, destination codes, per-phase card counts.
package dealer_pkg;

  localparam int unsigned DEST_W          = 4;
  localparam logic [3:0]  DEST_COMMUNITY  = 4'hF;
  localparam logic [3:0]  DEST_BURN       = 4'hE;
  localparam int unsigned FLOP_CARDS      = 3;
  localparam int unsigned TURN_CARDS      = 1;
  localparam int unsigned RIVER_CARDS     = 1;
  localparam int unsigned HOLE_PER_PLAYER = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL,
    ST_GAP,
    ST_BET,
    ST_SHOW,
    ST_END
  } state_e;

  typedef enum logic [1:0] {
    PH_HOLE,
    PH_FLOP,
    PH_TURN,
    PH_RIVER
  } phase_e;

endpackage

// File: rtl/dealer_sequencer_if.sv
// Deck request/acknowledge channel between the dealer sequencer and the deck/shuffler.
// Signals: deal_req (card request), deal_dest (card destination), deal_ack (card supplied).
// Modports: master = sequencer side, slave = deck side.
interface dealer_sequencer_if;
  import dealer_pkg::*;

  logic              deal_req;
  logic [DEST_W-1:0] deal_dest;
  logic              deal_ack;

  modport master (output deal_req, deal_dest, input deal_ack);
  modport slave  (input deal_req, deal_dest, output deal_ack);

endinterface

// File: rtl/deal_handshake.sv
// Card request engine for one deal phase: drives req/dest, inserts the one-cycle gap
// after every accepted card, counts cards against the phase target and flags completion.
// Ports: start_c/target_c/hole_c/burn_c load a new phase; ack from the deck;
//        req/dest registered request; phase_done_c marks the last non-burn ack.
module deal_handshake
  import dealer_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_c,
  input  logic [CNT_W-1:0]  target_c,
  input  logic              hole_c,
  input  logic              burn_c,
  input  logic              ack,
  output logic              req,
  output logic [DEST_W-1:0] dest,
  output logic              phase_done_c
);

  localparam int unsigned PIDX_W = 3;

  logic              active;
  logic              burn_pend;
  logic              hole_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  target_q;
  logic [PIDX_W-1:0] pidx;
  logic [PIDX_W-1:0] pidx_nxt;
  logic              take;
  logic              last;

  // A card is accepted only while a request is outstanding; gap-cycle acks fall out here.
  assign take         = active & req & ack;
  assign last         = (cnt + CNT_W'(1)) == target_q;
  assign phase_done_c = take & ~burn_pend & last;
  assign pidx_nxt     = (pidx == PIDX_W'(NUM_PLAYERS - 1)) ? '0 : pidx + PIDX_W'(1);

  // Request / gap sequencing and card counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      req       <= 1'b0;
      dest      <= '0;
      burn_pend <= 1'b0;
      hole_q    <= 1'b0;
      cnt       <= '0;
      target_q  <= '0;
      pidx      <= '0;
    end else if (start_c) begin
      active    <= 1'b1;
      req       <= 1'b1;
      burn_pend <= burn_c;
      hole_q    <= hole_c;
      cnt       <= '0;
      target_q  <= target_c;
      pidx      <= '0;
      dest      <= burn_c ? DEST_BURN : (hole_c ? '0 : DEST_COMMUNITY);
    end else if (take) begin
      req <= 1'b0;
      if (burn_pend) begin
        // Burn card is not part of the phase count.
        burn_pend <= 1'b0;
        dest      <= hole_q ? '0 : DEST_COMMUNITY;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          active <= 1'b0;
        end else if (hole_q) begin
          pidx <= pidx_nxt;
          dest <= DEST_W'(pidx_nxt);
        end
      end
    end else if (active && !req) begin
      req <= 1'b1;
    end
  end

endmodule

// File: rtl/dealer_sequencer.sv
// Poker hand sequencer: deals hole/flop/turn/river through the deck channel, waits for
// betting between phases, and emits single-cycle stage pulses move_to_1..5 and reset_game.
// Ports: clk, reset_n (async active-low), start_game, bet_done, one_player_left,
//        showdown_done; deck (master side of the request channel);
//        move_to_1..move_to_5, reset_game, busy (all registered).
// Build option: define BURN_CARD_EN to burn one card before flop, turn and river.
module dealer_sequencer
  import dealer_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_game,
  input  logic                bet_done,
  input  logic                one_player_left,
  input  logic                showdown_done,
  dealer_sequencer_if.master  deck,
  output logic                move_to_1,
  output logic                move_to_2,
  output logic                move_to_3,
  output logic                move_to_4,
  output logic                move_to_5,
  output logic                reset_game,
  output logic                busy
);

  localparam int unsigned HOLE_CARDS = HOLE_PER_PLAYER * NUM_PLAYERS;
  localparam int unsigned CNT_W      = $clog2(HOLE_CARDS + 1);
`ifdef BURN_CARD_EN
  localparam logic BURN_EN = 1'b1;
`else
  localparam logic BURN_EN = 1'b0;
`endif

  state_e           state, state_nxt;
  phase_e           phase, phase_nxt;
  logic [4:0]       move_q, move_nxt;
  logic             reset_game_nxt;
  logic             hs_start_c;
  logic             hs_hole_c;
  logic             hs_burn_c;
  logic [CNT_W-1:0] hs_target_c;
  logic             hs_done_c;

  function automatic logic [CNT_W-1:0] phase_cards(input phase_e p);
    case (p)
      PH_HOLE: return CNT_W'(HOLE_CARDS);
      PH_FLOP: return CNT_W'(FLOP_CARDS);
      PH_TURN: return CNT_W'(TURN_CARDS);
      default: return CNT_W'(RIVER_CARDS);
    endcase
  endfunction

  deal_handshake #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .CNT_W       (CNT_W)
  ) u_handshake (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_c      (hs_start_c),
    .target_c     (hs_target_c),
    .hole_c       (hs_hole_c),
    .burn_c       (hs_burn_c),
    .ack          (deck.deal_ack),
    .req          (deck.deal_req),
    .dest         (deck.deal_dest),
    .phase_done_c (hs_done_c)
  );

  // State register and registered pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= PH_HOLE;
      move_q     <= '0;
      reset_game <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      move_q     <= move_nxt;
      reset_game <= reset_game_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, phase launch and pulse decode.
  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    move_nxt       = '0;
    reset_game_nxt = 1'b0;
    hs_start_c     = 1'b0;
    hs_hole_c      = 1'b0;
    hs_burn_c      = 1'b0;
    hs_target_c    = phase_cards(phase);
    case (state)
      ST_IDLE: begin
        if (start_game) begin
          state_nxt   = ST_DEAL;
          phase_nxt   = PH_HOLE;
          hs_start_c  = 1'b1;
          hs_hole_c   = 1'b1;
          hs_target_c = phase_cards(PH_HOLE);
        end
      end
      ST_DEAL: begin
        // DEAL coincides with an outstanding request, so any ack here is accepted.
        if (hs_done_c) begin
          state_nxt = ST_BET;
          move_nxt  = 5'(1) << phase;
        end else if (deck.deal_ack) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: state_nxt = ST_DEAL;
      ST_BET: begin
        // Fold-out beats a simultaneous bet_done.
        if (one_player_left) begin
          state_nxt      = ST_END;
          reset_game_nxt = 1'b1;
        end else if (bet_done) begin
          if (phase == PH_RIVER) begin
            state_nxt = ST_SHOW;
            move_nxt  = 5'b10000;
          end else begin
            state_nxt   = ST_DEAL;
            phase_nxt   = phase_e'(2'(phase + 2'd1));
            hs_start_c  = 1'b1;
            hs_burn_c   = BURN_EN;
            hs_target_c = phase_cards(phase_nxt);
          end
        end
      end
      ST_SHOW: begin
        if (showdown_done) begin
          state_nxt      = ST_END;
          reset_game_nxt = 1'b1;
        end
      end
      ST_END:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign move_to_1 = move_q[0];
  assign move_to_2 = move_q[1];
  assign move_to_3 = move_q[2];
  assign move_to_4 = move_q[3];
  assign move_to_5 = move_q[4];

endmodule
